// File: rtl/updown_mod_counter_if.sv
// Bus bundle for updown_mod_counter.
// Control inputs travel from the user to the counter. Count state travels back.
// There is no valid/ready handshake here. Every control input is sampled on each
// rising clk edge, and its effect shows on Q/tc/wrap_cnt one clock later.
interface updown_mod_counter_if #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 4
);
    logic              en;
    logic              up_dn;
    logic              sat_mode;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  mod_val;
    logic              clr_wrap;
    logic [WIDTH-1:0]  Q;
    logic              tc;
    logic [WRAP_W-1:0] wrap_cnt;

    // Side that controls the counter and observes it
    modport master (
        output en, up_dn, sat_mode, load, load_val, mod_val, clr_wrap,
        input  Q, tc, wrap_cnt
    );

    // The counter itself
    modport slave (
        input  en, up_dn, sat_mode, load, load_val, mod_val, clr_wrap,
        output Q, tc, wrap_cnt
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Programmable-modulus up/down counter.
// Features: parallel load with clamp, count enable, and wrap or saturate at the
// boundaries. It also provides a registered terminal-count pulse and a saturating
// counter of wrap events.
// Counting range is 0..mod_val inclusive. A Q left above mod_val by a mod_val
// change is treated as a boundary when counting up, and simply decrements when
// counting down.
module updown_mod_counter #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 4
) (
    input logic                clk,
    input logic                reset,
    updown_mod_counter_if.slave bus
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    logic [WIDTH-1:0]  q_r;
    logic              tc_r;
    logic [WRAP_W-1:0] wrap_r;

    logic [WIDTH-1:0]  q_next;
    logic              tc_next;
    logic              wrap_event;
    logic [WRAP_W-1:0] wrap_next;

    // Next count, terminal-count flag and wrap event (load beats enable)
    always_comb begin
        q_next     = q_r;
        tc_next    = 1'b0;
        wrap_event = 1'b0;
        if (bus.load) begin
            q_next = (bus.load_val > bus.mod_val) ? bus.mod_val : bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (q_r < bus.mod_val) begin
                    q_next = q_r + 1'b1;
                end else begin
                    tc_next    = 1'b1;
                    wrap_event = ~bus.sat_mode;
                    q_next     = bus.sat_mode ? bus.mod_val : '0;
                end
            end else begin
                if (q_r != '0) begin
                    q_next = q_r - 1'b1;
                end else begin
                    tc_next    = 1'b1;
                    wrap_event = ~bus.sat_mode;
                    q_next     = bus.sat_mode ? '0 : bus.mod_val;
                end
            end
        end
    end

    // Next wrap count: clear wins over a simultaneous wrap; saturates at all-ones
    always_comb begin
        wrap_next = wrap_r;
        if (bus.clr_wrap) begin
            wrap_next = '0;
        end else if (wrap_event && (wrap_r != WRAP_MAX)) begin
            wrap_next = wrap_r + 1'b1;
        end
    end

    // State registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r    <= '0;
            tc_r   <= 1'b0;
            wrap_r <= '0;
        end else begin
            q_r    <= q_next;
            tc_r   <= tc_next;
            wrap_r <= wrap_next;
        end
    end

    assign bus.Q        = q_r;
    assign bus.tc       = tc_r;
    assign bus.wrap_cnt = wrap_r;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed testbench for updown_mod_counter (WIDTH=3, WRAP_W=4).
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at the same
// point, after the edge's update has settled.
module tb_updown_mod_counter;

    localparam int WIDTH  = 3;
    localparam int WRAP_W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    updown_mod_counter_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

    updown_mod_counter #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int eq, input int etc, input int ewc);
        check({tag, ".Q"},        32'(bus.Q),        32'(eq));
        check({tag, ".tc"},       32'(bus.tc),       32'(etc));
        check({tag, ".wrap_cnt"}, 32'(bus.wrap_cnt), 32'(ewc));
    endtask

    // Advance one edge, then check all three outputs
    task automatic tick(input string tag, input int eq, input int etc, input int ewc);
        @(posedge clk);
        #1;
        check_all(tag, eq, etc, ewc);
    endtask

    task automatic drive(input logic en, input logic up_dn, input logic sat_mode,
                         input int mod_val);
        bus.en       = en;
        bus.up_dn    = up_dn;
        bus.sat_mode = sat_mode;
        bus.mod_val  = WIDTH'(mod_val);
    endtask

    int up_q[7]   = '{1, 2, 3, 4, 5, 0, 1};
    int up_tc[7]  = '{0, 0, 0, 0, 0, 1, 0};
    int up_wc[7]  = '{0, 0, 0, 0, 0, 1, 1};
    int sat_q[6]  = '{1, 2, 3, 4, 4, 4};
    int sat_tc[6] = '{0, 0, 0, 0, 1, 1};
    int dn_q[6]   = '{3, 2, 1, 0, 0, 0};
    int dn_tc[6]  = '{0, 0, 0, 0, 1, 1};

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 0);
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.clr_wrap = 1'b0;

        // Reset held for two cycles
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0);

        // Wrap up, mod 5
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5);
        for (int i = 0; i < 7; i++) tick("wrap_up", up_q[i], up_tc[i], up_wc[i]);

        // Load 0 under mod 7, then count down through full range
        bus.load     = 1'b1;
        bus.load_val = 3'd0;
        drive(1'b1, 1'b0, 1'b0, 7);
        tick("load0", 0, 0, 1);
        bus.load = 1'b0;
        tick("down_first_wrap", 7, 1, 2);
        for (int i = 6; i >= 0; i--) tick("down_step", i, 0, 2);
        tick("down_second_wrap", 7, 1, 3);
        for (int k = 0; k < 17; k++) begin
            repeat (7) @(posedge clk);
            tick("down_wrap_sat", 7, 1, (4 + k > 15) ? 15 : 4 + k);
        end

        // Saturate up to 4, clearing wrap_cnt during the load
        bus.load     = 1'b1;
        bus.load_val = 3'd0;
        bus.clr_wrap = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 4);
        tick("sat_load_clr", 0, 0, 0);
        bus.load     = 1'b0;
        bus.clr_wrap = 1'b0;
        for (int i = 0; i < 6; i++) tick("sat_up", sat_q[i], sat_tc[i], 0);
        bus.up_dn = 1'b0;
        for (int i = 0; i < 6; i++) tick("sat_down", dn_q[i], dn_tc[i], 0);

        // Load priority over en, with clamp to mod_val
        bus.load     = 1'b1;
        bus.load_val = 3'd6;
        drive(1'b1, 1'b1, 1'b0, 3);
        tick("load_clamp", 3, 0, 0);
        bus.load_val = 3'd2;
        tick("load_over_en", 2, 0, 0);
        bus.load = 1'b0;
        tick("after_load", 3, 0, 0);
        tick("after_load_wrap", 0, 1, 1);

        // Lower mod_val while Q sits above it
        bus.load     = 1'b1;
        bus.load_val = 3'd6;
        drive(1'b1, 1'b1, 1'b0, 7);
        tick("load6", 6, 0, 1);
        bus.load = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2);
        tick("mod_drop", 0, 1, 2);

        // Down count from an out-of-range value just decrements
        bus.load     = 1'b1;
        bus.load_val = 3'd7;
        drive(1'b1, 1'b0, 1'b0, 7);
        tick("load7", 7, 0, 2);
        bus.load = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2);
        tick("oor_down", 6, 0, 2);

        // mod_val = 0: every enabled step is a boundary
        bus.load     = 1'b1;
        bus.load_val = 3'd0;
        tick("load_zero", 0, 0, 2);
        bus.load = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 0);
        tick("mod0_up_a", 0, 1, 3);
        tick("mod0_up_b", 0, 1, 4);
        bus.up_dn = 1'b0;
        tick("mod0_down", 0, 1, 5);

        // clr_wrap coincident with a wrap event
        bus.clr_wrap = 1'b1;
        tick("clr_vs_wrap", 0, 1, 0);
        bus.clr_wrap = 1'b0;
        tick("after_clr", 0, 1, 1);

        // Enable low holds Q and drops tc
        bus.load     = 1'b1;
        bus.load_val = 3'd5;
        drive(1'b1, 1'b1, 1'b0, 7);
        tick("load5", 5, 0, 1);
        bus.load = 1'b0;
        bus.en   = 1'b0;
        tick("hold_a", 5, 0, 1);
        tick("hold_b", 5, 0, 1);

        // Asynchronous reset between edges clears without a clock edge
        bus.en = 1'b1;
        tick("pre_reset", 6, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("reset_held", 0, 0, 0);
        reset = 1'b1;
        tick("post_reset", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
